// File: rtl/tcb_pkg.sv
// Shared types and helpers for the TCB stream manager.
// Macro TCB_MAN_STREAM_BEN_MASK_EN adds byte-enable tracking to rsp_entry_t.
package tcb_pkg;

  // The response entry is sized for the default data bus width.
  localparam int unsigned TCB_DBW = 32;
  localparam int unsigned TCB_BEW = TCB_DBW / 8;

  typedef struct packed {
    logic [TCB_DBW-1:0] rdt;
    logic               err;
    logic               wen;
`ifdef TCB_MAN_STREAM_BEN_MASK_EN
    logic [TCB_BEW-1:0] ben;
`endif
  } rsp_entry_t;

  // The credit counter must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tcb_man_stream_fifo.sv
// Response FIFO for the TCB stream manager; head entry is read straight from storage.
// Entry layout depends on macro TCB_MAN_STREAM_BEN_MASK_EN (see tcb_pkg).
module tcb_man_stream_fifo
  import tcb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  rsp_entry_t i_ent,
  input  logic       i_pop,
  output rsp_entry_t o_ent,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  rsp_entry_t      r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]});
  assign o_ent   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (i_pop && !o_empty) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/tcb_man_stream.sv
// TCB manager: valid/ready command stream in, TCB requests out, buffered responses back.
// Macro TCB_MAN_STREAM_BEN_MASK_EN zeroes read-data bytes whose byte enable was 0.
module tcb_man_stream
  import tcb_pkg::*;
#(
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = TCB_DBW,
  parameter int unsigned BEW = DBW / 8,
  parameter int unsigned DLY = 1,
  parameter int unsigned RFD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic           cmd_wen,
  input  logic [ABW-1:0] cmd_adr,
  input  logic [BEW-1:0] cmd_ben,
  input  logic [DBW-1:0] cmd_wdt,
  output logic           rsp_vld,
  input  logic           rsp_rdy,
  output logic [DBW-1:0] rsp_rdt,
  output logic           rsp_err,
  output logic           tcb_vld,
  output logic           tcb_wen,
  output logic [ABW-1:0] tcb_adr,
  output logic [BEW-1:0] tcb_ben,
  output logic [DBW-1:0] tcb_wdt,
  input  logic           tcb_rdy,
  input  logic [DBW-1:0] tcb_rdt,
  input  logic           tcb_err
);

  localparam int unsigned CW = cnt_width(RFD);

  logic [CW-1:0] r_cnt;
  logic          w_ok;
  logic          w_trn;
  logic          w_pop;
  logic          w_rph_vld;
  logic          w_rph_wen;
  logic          w_full;
  logic          w_empty;
  rsp_entry_t    w_push_ent;
  rsp_entry_t    w_head;
`ifdef TCB_MAN_STREAM_BEN_MASK_EN
  logic [BEW-1:0] w_rph_ben;
`endif

  // A request may only go out when a FIFO slot is guaranteed for its response.
  assign w_ok    = rst & (r_cnt < CW'(RFD));
  assign tcb_vld = cmd_vld & w_ok;
  assign cmd_rdy = tcb_rdy & w_ok;
  assign tcb_wen = cmd_wen;
  assign tcb_adr = cmd_adr;
  assign tcb_ben = cmd_ben;
  assign tcb_wdt = cmd_wdt;

  assign w_trn   = tcb_vld & tcb_rdy;
  assign rsp_vld = rst & ~w_empty;
  assign w_pop   = rsp_vld & rsp_rdy;

  // Credits: in-flight transfers plus buffered responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_trn && !w_pop) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (!w_trn && w_pop) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  generate
    if (DLY == 0) begin : g_dly0
      assign w_rph_vld = w_trn;
      assign w_rph_wen = cmd_wen;
`ifdef TCB_MAN_STREAM_BEN_MASK_EN
      assign w_rph_ben = cmd_ben;
`endif
    end else begin : g_trk
      logic [DLY-1:0] r_trk_vld;
      logic [DLY-1:0] r_trk_wen;
`ifdef TCB_MAN_STREAM_BEN_MASK_EN
      logic [DLY-1:0][BEW-1:0] r_trk_ben;
`endif

      // Only the valid bits need reset; late responses then find no owner.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_trk_vld <= '0;
        end else begin
          r_trk_vld[0] <= w_trn;
          for (int i = 1; i < DLY; i++) begin
            r_trk_vld[i] <= r_trk_vld[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        r_trk_wen[0] <= cmd_wen;
`ifdef TCB_MAN_STREAM_BEN_MASK_EN
        r_trk_ben[0] <= cmd_ben;
`endif
        for (int i = 1; i < DLY; i++) begin
          r_trk_wen[i] <= r_trk_wen[i-1];
`ifdef TCB_MAN_STREAM_BEN_MASK_EN
          r_trk_ben[i] <= r_trk_ben[i-1];
`endif
        end
      end

      assign w_rph_vld = r_trk_vld[DLY-1];
      assign w_rph_wen = r_trk_wen[DLY-1];
`ifdef TCB_MAN_STREAM_BEN_MASK_EN
      assign w_rph_ben = r_trk_ben[DLY-1];
`endif
    end
  endgenerate

  always_comb begin
    w_push_ent     = '0;
    w_push_ent.rdt = TCB_DBW'(tcb_rdt);
    w_push_ent.err = tcb_err;
    w_push_ent.wen = w_rph_wen;
`ifdef TCB_MAN_STREAM_BEN_MASK_EN
    w_push_ent.ben = TCB_BEW'(w_rph_ben);
`endif
  end

  tcb_man_stream_fifo #(
    .DEPTH (RFD)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rph_vld),
    .i_ent   (w_push_ent),
    .i_pop   (w_pop),
    .o_ent   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Write responses carry no data; reads optionally drop disabled bytes.
  always_comb begin
    rsp_rdt = '0;
    if (!w_head.wen) begin
`ifdef TCB_MAN_STREAM_BEN_MASK_EN
      for (int b = 0; b < BEW; b++) begin
        if (w_head.ben[b]) begin
          rsp_rdt[8*b +: 8] = w_head.rdt[8*b +: 8];
        end
      end
`else
      rsp_rdt = DBW'(w_head.rdt);
`endif
    end
  end

  assign rsp_err = w_head.err;

  always @(posedge clk) begin
    if (rst) begin
      assert (!(w_rph_vld && w_full && !w_pop))
        else $error("response FIFO push while full");
    end
  end

endmodule
